// File: rtl/avg_pool_stencil_1_sched_ctrl_if.sv
// Purpose : iteration-issue bundle between the avg_pool schedule controller and its consumers.
// Latency : none (wires only).
// Backpress: stall flows from consumer to controller and freezes the schedule.
//
// Signals:
//   stall     - consumer -> controller, freezes all schedule state
//   valid     - controller -> consumer, one-cycle iteration-issue strobe
//   ctrl_vars - controller -> consumer, current iteration vector (4 x 16 bit)
//   done      - controller -> consumer, sticky "all iterations issued"
interface avg_pool_stencil_1_sched_ctrl_if;
  logic             stall;
  logic             valid;
  logic [3:0][15:0] ctrl_vars;
  logic             done;

  modport master (input stall, output valid, output ctrl_vars, output done);
  modport slave  (output stall, input valid, input ctrl_vars, input done);
endinterface

// File: rtl/avg_pool_stencil_1_sched_ctrl.sv
// Purpose : issues the {0} x EXT1 x EXT2 x EXT3 iteration schedule for the avg_pool stencil.
// Latency : first valid START_DELAY cycles after flush drops, then one every II cycles.
// Backpress: stall freezes state and masks valid; a masked issue fires once stall drops.
//
// Ports:
//   clk   - single clock, all state on the rising edge
//   flush - synchronous active-high restart, wins over stall and every transition
//   sched - master side of the issue bundle (stall in; valid/ctrl_vars/done out)
module avg_pool_stencil_1_sched_ctrl #(
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned II          = 1,
  parameter int unsigned EXT1        = 4,
  parameter int unsigned EXT2        = 32,
  parameter int unsigned EXT3        = 32
) (
  input  logic                            clk,
  input  logic                            flush,
  avg_pool_stencil_1_sched_ctrl_if.master sched
);

  localparam logic [15:0] DELAY_END = 16'(START_DELAY);
  localparam logic [15:0] PHASE_END = 16'(II - 1);
  localparam logic [15:0] LAST1     = 16'(EXT1 - 1);
  localparam logic [15:0] LAST2     = 16'(EXT2 - 1);
  localparam logic [15:0] LAST3     = 16'(EXT3 - 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] delay_q, delay_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] cv1_q, cv1_d;
  logic [15:0] cv2_q, cv2_d;
  logic [15:0] cv3_q, cv3_d;
  logic        done_q, done_d;

  logic run_now;
  logic issue;
  logic last_iter;

  // WAIT with the delay already met acts as RUN for this cycle, so the
  // first iteration issues on the very cycle the delay expires (cycle 0
  // when START_DELAY is 0) rather than one cycle later.
  assign run_now   = (state_q == S_RUN) ||
                     ((state_q == S_WAIT) && (delay_q == DELAY_END));
  assign last_iter = (cv1_q == LAST1) && (cv2_q == LAST2) && (cv3_q == LAST3);
  assign issue     = run_now && (phase_q == 16'd0) && !sched.stall && !flush;

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    phase_d = phase_q;
    cv1_d   = cv1_q;
    cv2_d   = cv2_q;
    cv3_d   = cv3_q;
    done_d  = done_q;

    // DONE ignores stall entirely; everything else freezes under it.
    if (!sched.stall && (state_q != S_DONE)) begin
      if ((state_q == S_WAIT) && (delay_q != DELAY_END)) begin
        delay_d = delay_q + 16'd1;
      end

      if (run_now) begin
        state_d = S_RUN;
        phase_d = (phase_q == PHASE_END) ? 16'd0 : phase_q + 16'd1;

        if (phase_q == 16'd0) begin
          if (last_iter) begin
            // Hold the final vector for the whole DONE period.
            state_d = S_DONE;
            done_d  = 1'b1;
            phase_d = 16'd0;
          end else if (cv3_q == LAST3) begin
            cv3_d = 16'd0;
            if (cv2_q == LAST2) begin
              cv2_d = 16'd0;
              cv1_d = cv1_q + 16'd1;
            end else begin
              cv2_d = cv2_q + 16'd1;
            end
          end else begin
            cv3_d = cv3_q + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= S_WAIT;
      delay_q <= 16'd0;
      phase_q <= 16'd0;
      cv1_q   <= 16'd0;
      cv2_q   <= 16'd0;
      cv3_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      phase_q <= phase_d;
      cv1_q   <= cv1_d;
      cv2_q   <= cv2_d;
      cv3_q   <= cv3_d;
      done_q  <= done_d;
    end
  end

  assign sched.valid     = issue;
  assign sched.ctrl_vars = {cv3_q, cv2_q, cv1_q, 16'd0};
  assign sched.done      = done_q;

endmodule

// File: tb/tb_avg_pool_stencil_1_sched_ctrl.sv
// Purpose : directed scoreboard bench for the avg_pool schedule controller.
// Latency : n/a.
// Backpress: drives stall directly on the interface.
module tb_avg_pool_stencil_1_sched_ctrl;

  logic clk;
  logic flush_a;
  logic flush_b;

  avg_pool_stencil_1_sched_ctrl_if bus_a ();
  avg_pool_stencil_1_sched_ctrl_if bus_b ();

  avg_pool_stencil_1_sched_ctrl dut_a (
    .clk   (clk),
    .flush (flush_a),
    .sched (bus_a)
  );

  avg_pool_stencil_1_sched_ctrl #(
    .START_DELAY(5), .II(3), .EXT1(1), .EXT2(2), .EXT3(2)
  ) dut_b (
    .clk   (clk),
    .flush (flush_b),
    .sched (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] v;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc_a  = 0;
  int cyc_b  = 0;
  int last_a = -1;

  // Cycle index relative to the last flush edge: during the period that
  // ends at the Nth non-flush edge, cyc_x reads N.
  always @(posedge clk) begin
    if (flush_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    if (flush_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pk(input int c, input int r, input int col);
    return {16'(col), 16'(r), 16'(c), 16'd0};
  endfunction

  // Expected issue order for the default 4x32x32 domain; iterations at or
  // beyond stall_at slip by stall_len cycles.
  task automatic push_a(input int stall_at, input int stall_len, input int limit);
    exp_t e;
    int   i;
    i = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 32; r++)
        for (int col = 0; col < 32; col++) begin
          if (i < limit) begin
            e.cyc = (i >= stall_at) ? i + stall_len : i;
            e.v   = pk(c, r, col);
            q_a.push_back(e);
          end
          i++;
        end
  endtask

  always @(negedge clk) begin
    if (bus_a.valid === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_valid", {32'd0, cyc_a}, 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_issue_cycle", 64'(cyc_a), 64'(e.cyc));
        chk("a_ctrl_vars", bus_a.ctrl_vars, e.v);
        last_a = cyc_a;
      end
    end
    if (bus_b.valid === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_valid", {32'd0, cyc_b}, 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_issue_cycle", 64'(cyc_b), 64'(e.cyc));
        chk("b_ctrl_vars", bus_b.ctrl_vars, e.v);
      end
    end
  end

  initial begin
    exp_t e;
    int   k;

    flush_a     = 1'b1;
    flush_b     = 1'b1;
    bus_a.stall = 1'b0;
    bus_b.stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_reset_valid", 64'(bus_a.valid), 64'd0);
    chk("a_reset_done", 64'(bus_a.done), 64'd0);
    chk("a_reset_vars", bus_a.ctrl_vars, 64'd0);
    chk("b_reset_valid", 64'(bus_b.valid), 64'd0);
    chk("b_reset_done", 64'(bus_b.done), 64'd0);

    // Delayed, strided schedule on the small instance.
    e.cyc = 5;  e.v = pk(0, 0, 0); q_b.push_back(e);
    e.cyc = 8;  e.v = pk(0, 0, 1); q_b.push_back(e);
    e.cyc = 11; e.v = pk(0, 1, 0); q_b.push_back(e);
    e.cyc = 14; e.v = pk(0, 1, 1); q_b.push_back(e);
    @(posedge clk); #1;
    flush_b = 1'b0;
    for (k = 0; k < 100 && bus_b.done !== 1'b1; k++) @(negedge clk);
    chk("b_done", 64'(bus_b.done), 64'd1);
    chk("b_done_cycle", 64'(cyc_b), 64'd15);
    chk("b_all_issued", 64'(q_b.size()), 64'd0);
    chk("b_final_vars", bus_b.ctrl_vars, pk(0, 1, 1));

    // Full default run from flush.
    push_a(1 << 30, 0, 4096);
    @(posedge clk); #1;
    flush_a = 1'b0;
    for (k = 0; k < 5000 && bus_a.done !== 1'b1; k++) @(negedge clk);
    chk("a_done", 64'(bus_a.done), 64'd1);
    chk("a_done_cycle", 64'(cyc_a), 64'd4096);
    chk("a_all_issued", 64'(q_a.size()), 64'd0);
    chk("a_last_valid_cycle", 64'(last_a), 64'd4095);

    // Stall has no effect in DONE.
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      bus_a.stall = ~bus_a.stall;
      @(negedge clk);
      chk("a_done_stall_valid", 64'(bus_a.valid), 64'd0);
      chk("a_done_stall_done", 64'(bus_a.done), 64'd1);
      chk("a_done_stall_vars", bus_a.ctrl_vars, pk(3, 31, 31));
    end
    @(posedge clk); #1;
    bus_a.stall = 1'b0;

    // Stall on cycles 10..13 shifts the tail by four cycles.
    push_a(10, 4, 4096);
    flush_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    @(negedge clk);
    chk("a_restart_done", 64'(bus_a.done), 64'd0);
    for (k = 0; k < 5000 && bus_a.done !== 1'b1; k++) begin
      @(posedge clk); #1;
      if (cyc_a == 10) bus_a.stall = 1'b1;
      if (cyc_a == 14) bus_a.stall = 1'b0;
    end
    bus_a.stall = 1'b0;
    chk("a_stall_done", 64'(bus_a.done), 64'd1);
    chk("a_stall_last_cycle", 64'(last_a), 64'd4099);
    chk("a_stall_all_issued", 64'(q_a.size()), 64'd0);

    // Flush pulse at cycle 100 discards progress.
    push_a(1 << 30, 0, 100);
    flush_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    for (k = 0; k < 200 && cyc_a != 100; k++) begin
      @(posedge clk); #1;
    end
    chk("a_mid_reach_100", 64'(cyc_a), 64'd100);
    flush_a = 1'b1;
    @(negedge clk);
    chk("a_mid_flush_valid", 64'(bus_a.valid), 64'd0);
    chk("a_mid_consumed", 64'(q_a.size()), 64'd0);
    push_a(1 << 30, 0, 4096);
    @(posedge clk); #1;
    flush_a = 1'b0;
    chk("a_mid_vars_cleared", bus_a.ctrl_vars, 64'd0);
    chk("a_mid_done_cleared", 64'(bus_a.done), 64'd0);
    for (k = 0; k < 5000 && bus_a.done !== 1'b1; k++) @(negedge clk);
    chk("a_mid_done", 64'(bus_a.done), 64'd1);
    chk("a_mid_all_issued", 64'(q_a.size()), 64'd0);

    // Flush and stall together; flush wins, first issue when both drop.
    flush_a     = 1'b1;
    bus_a.stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("a_flush_stall_valid", 64'(bus_a.valid), 64'd0);
    end
    push_a(1 << 30, 0, 4096);
    @(posedge clk); #1;
    flush_a     = 1'b0;
    bus_a.stall = 1'b0;
    @(negedge clk);
    chk("a_fs_first_valid", 64'(bus_a.valid), 64'd1);
    for (k = 0; k < 5000 && bus_a.done !== 1'b1; k++) @(negedge clk);
    chk("a_fs_done", 64'(bus_a.done), 64'd1);
    chk("a_fs_last_cycle", 64'(last_a), 64'd4095);
    chk("a_fs_all_issued", 64'(q_a.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
